// File: rtl/stopwatch_button_conditioner.sv
// stopwatch_button_conditioner
//
// Turns the three raw, bouncing, active-low board keys into the clean control
// signals consumed by StopwatchLogic. Each key is synchronised (2 flops) and
// debounced. Start presses become a fixed-width active-low pulse, hold presses
// toggle a level, and a long press of clear emits a fixed-width active-low
// reset pulse that also forces the other two outputs to their idle values.
//
// Ports:
//   CLK_100Hz    in   100 Hz system clock, all logic on its rising edge
//   reset        in   synchronous active-high reset
//   key_start_n  in   raw start/stop key, active low, asynchronous
//   key_hold_n   in   raw hold key, active low, asynchronous
//   key_clear_n  in   raw clear key, active low, asynchronous
//   start_stop   out  active-low pulse, PULSE_CYCLES wide, one per press
//   hold         out  1 = display running, 0 = frozen; toggles per press
//   reset_n      out  active-low pulse, PULSE_CYCLES wide, after a long clear
module stopwatch_button_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES   = 3,
    parameter int unsigned PULSE_CYCLES      = 10,
    parameter int unsigned LONG_PRESS_CYCLES = 100
) (
    input  logic CLK_100Hz,
    input  logic reset,
    input  logic key_start_n,
    input  logic key_hold_n,
    input  logic key_clear_n,
    output logic start_stop,
    output logic hold,
    output logic reset_n
);

    localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned PW = $clog2(PULSE_CYCLES + 1);
    localparam int unsigned LW = $clog2(LONG_PRESS_CYCLES + 1);

    localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [DW-1:0] DEB_ONE    = DW'(1);
    localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_CYCLES - 1);
    localparam logic [PW-1:0] PULSE_ONE  = PW'(1);
    localparam logic [LW-1:0] LONG_LAST  = LW'(LONG_PRESS_CYCLES - 1);
    localparam logic [LW-1:0] LONG_ONE   = LW'(1);

    localparam int K_START = 0;
    localparam int K_HOLD  = 1;
    localparam int K_CLEAR = 2;

    typedef enum logic {S_IDLE, S_PULSE} start_state_e;
    typedef enum logic [1:0] {C_IDLE, C_ARMED, C_FIRE, C_WAIT} clear_state_e;

    logic [2:0]         raw;
    logic [2:0]         sync1;
    logic [2:0]         sync2;
    logic [2:0]         deb;
    logic [2:0]         deb_prev;
    logic [2:0][DW-1:0] deb_cnt;
    logic [2:0]         press;

    start_state_e       st_state;
    logic [PW-1:0]      st_cnt;

    clear_state_e       clr_state;
    logic [LW-1:0]      long_cnt;
    logic [PW-1:0]      fire_cnt;

    logic               fire_entry;
    logic               block;

    assign raw = {key_clear_n, key_hold_n, key_start_n};

    // Two-flop synchronisers, released (1) out of reset.
    always_ff @(posedge CLK_100Hz) begin
        if (reset) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Debouncers: deb follows sync2 only after DEBOUNCE_CYCLES consecutive
    // disagreeing samples; the edge that sees the last one updates deb.
    always_ff @(posedge CLK_100Hz) begin
        if (reset) begin
            deb      <= '1;
            deb_prev <= '1;
            deb_cnt  <= '0;
        end else begin
            deb_prev <= deb;
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] != deb[i]) begin
                    if (deb_cnt[i] == DEB_LAST) begin
                        deb[i]     <= sync2[i];
                        deb_cnt[i] <= '0;
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + DEB_ONE;
                    end
                end else begin
                    deb_cnt[i] <= '0;
                end
            end
        end
    end

    // Press event: debounced level went 1 -> 0 on the previous edge.
    assign press = deb_prev & ~deb;

    // Clear takes priority: on the edge it fires and while it is firing,
    // start and hold are held at their idle values and their presses dropped.
    assign fire_entry = (clr_state == C_ARMED) && !deb[K_CLEAR] && (long_cnt == LONG_LAST);
    assign block      = fire_entry || (clr_state == C_FIRE);

    // Start/stop pulse generator.
    always_ff @(posedge CLK_100Hz) begin
        if (reset) begin
            st_state   <= S_IDLE;
            st_cnt     <= '0;
            start_stop <= 1'b1;
        end else if (block) begin
            st_state   <= S_IDLE;
            st_cnt     <= '0;
            start_stop <= 1'b1;
        end else begin
            unique case (st_state)
                S_IDLE: begin
                    if (press[K_START]) begin
                        st_state   <= S_PULSE;
                        st_cnt     <= '0;
                        start_stop <= 1'b0;
                    end
                end
                S_PULSE: begin
                    // Presses arriving here are dropped.
                    if (st_cnt == PULSE_LAST) begin
                        st_state   <= S_IDLE;
                        st_cnt     <= '0;
                        start_stop <= 1'b1;
                    end else begin
                        st_cnt <= st_cnt + PULSE_ONE;
                    end
                end
            endcase
        end
    end

    // Hold toggle latch.
    always_ff @(posedge CLK_100Hz) begin
        if (reset) begin
            hold <= 1'b1;
        end else if (fire_entry) begin
            hold <= 1'b1;
        end else if ((clr_state != C_FIRE) && press[K_HOLD]) begin
            hold <= ~hold;
        end
    end

    // Long-press clear. long_cnt counts edges spent armed, starting at 1 on
    // the arming edge; the fire edge is the one that would bring it to
    // LONG_PRESS_CYCLES. C_WAIT blocks re-arming until the key is released.
    always_ff @(posedge CLK_100Hz) begin
        if (reset) begin
            clr_state <= C_IDLE;
            long_cnt  <= '0;
            fire_cnt  <= '0;
            reset_n   <= 1'b1;
        end else begin
            unique case (clr_state)
                C_IDLE: begin
                    if (press[K_CLEAR]) begin
                        clr_state <= C_ARMED;
                        long_cnt  <= LONG_ONE;
                    end
                end
                C_ARMED: begin
                    if (deb[K_CLEAR]) begin
                        clr_state <= C_IDLE;
                        long_cnt  <= '0;
                    end else if (long_cnt == LONG_LAST) begin
                        clr_state <= C_FIRE;
                        long_cnt  <= '0;
                        fire_cnt  <= '0;
                        reset_n   <= 1'b0;
                    end else begin
                        long_cnt <= long_cnt + LONG_ONE;
                    end
                end
                C_FIRE: begin
                    if (fire_cnt == PULSE_LAST) begin
                        clr_state <= C_WAIT;
                        fire_cnt  <= '0;
                        reset_n   <= 1'b1;
                    end else begin
                        fire_cnt <= fire_cnt + PULSE_ONE;
                    end
                end
                C_WAIT: begin
                    if (deb[K_CLEAR]) begin
                        clr_state <= C_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stopwatch_button_conditioner.sv
// Testbench for stopwatch_button_conditioner.
// A reference model, driven edge by edge alongside the stimulus, predicts every
// change of the output vector {reset_n, hold, start_stop} and queues it with the
// edge number it must appear on. A separate monitor pops the queue whenever the
// DUT output changes, and flags changes that are late, early, wrong or missing.
module tb_stopwatch_button_conditioner;

    localparam int DEB  = 3;
    localparam int P    = 10;
    localparam int LONG = 100;
    localparam int MAXC = 20000;

    localparam logic [2:0] REL       = 3'b111;
    localparam logic [2:0] K_START   = 3'b110;
    localparam logic [2:0] K_HOLD    = 3'b101;
    localparam logic [2:0] K_CLEAR   = 3'b011;
    localparam logic [2:0] K_CLR_STA = 3'b010;

    logic clk         = 1'b0;
    logic reset       = 1'b1;
    logic key_start_n = 1'b1;
    logic key_hold_n  = 1'b1;
    logic key_clear_n = 1'b1;
    logic start_stop;
    logic hold;
    logic reset_n;

    stopwatch_button_conditioner #(
        .DEBOUNCE_CYCLES  (DEB),
        .PULSE_CYCLES     (P),
        .LONG_PRESS_CYCLES(LONG)
    ) dut (
        .CLK_100Hz  (clk),
        .reset      (reset),
        .key_start_n(key_start_n),
        .key_hold_n (key_hold_n),
        .key_clear_n(key_clear_n),
        .start_stop (start_stop),
        .hold       (hold),
        .reset_n    (reset_n)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int         cyc;
        logic [2:0] vec;
    } ev_t;
    ev_t exp_q[$];

    // Model history, indexed by edge number (edge 0 = before simulation).
    bit [2:0] raw_h[MAXC];
    bit       rst_h[MAXC];
    bit [2:0] deb_h[MAXC];
    int       pulse_at = -1;  // edge the current start pulse went low
    int       armed_at = -1;  // edge the clear key was armed
    int       fire_at  = -1;  // edge reset_n went low; cleared once released
    bit       hold_m   = 1'b1;
    logic [2:0] cur_exp = 3'b111;

    // Key level the debouncer compares on edge m: the raw value two edges
    // earlier, or released if the synchroniser was reset in between.
    function automatic bit seen(input int k, input int m);
        if (m < 2) return 1'b1;
        if (rst_h[m-1] || rst_h[m-2]) return 1'b1;
        return raw_h[m-2][k];
    endfunction

    task automatic model_edge(input bit rst, input logic [2:0] keys);
        int         n;
        bit         prev;
        bit         flip;
        bit [2:0]   press;
        bit         c_d;
        bit         in_fire;
        bit         fire_now;
        bit         busy;
        logic [2:0] e;
        n = cyc + 1;
        if (n >= MAXC) begin
            $display("FAIL model_overflow edge=%0d limit=%0d", n, MAXC);
            $fatal(1, "history exhausted");
        end
        raw_h[n] = keys;
        rst_h[n] = rst;
        if (rst) begin
            deb_h[n] = 3'b111;
            pulse_at = -1;
            armed_at = -1;
            fire_at  = -1;
            hold_m   = 1'b1;
            e        = 3'b111;
        end else begin
            for (int k = 0; k < 3; k++) begin
                prev = deb_h[n-1][k];
                // deb flips once the last DEB compared samples, all after any
                // reset, disagree with it.
                flip = 1'b1;
                for (int j = 0; j < DEB; j++) begin
                    if ((n - j) < 1 || rst_h[n-j] || seen(k, n - j) == prev) flip = 1'b0;
                end
                deb_h[n][k] = flip ? ~prev : prev;
                press[k] = (n >= 2) && deb_h[n-2][k] && !deb_h[n-1][k];
            end
            c_d      = deb_h[n-1][2];
            in_fire  = (fire_at >= 0) && (n >= fire_at + 1) && (n <= fire_at + P);
            fire_now = 1'b0;
            if (armed_at >= 0) begin
                if (c_d) armed_at = -1;
                else if (n - armed_at == LONG - 1) begin
                    fire_now = 1'b1;
                    fire_at  = n;
                    armed_at = -1;
                end
            end else if (fire_at >= 0) begin
                if (n > fire_at + P && c_d) fire_at = -1;
            end else if (press[2]) begin
                armed_at = n;
            end
            busy = (pulse_at >= 0) && (n <= pulse_at + P);
            if (fire_now || in_fire) pulse_at = -1;
            else if (!busy && press[0]) pulse_at = n;
            if (fire_now) hold_m = 1'b1;
            else if (!in_fire && press[1]) hold_m = ~hold_m;
            e[0] = !((pulse_at >= 0) && (n <= pulse_at + P - 1));
            e[1] = hold_m;
            e[2] = !((fire_at >= 0) && (n >= fire_at) && (n <= fire_at + P - 1));
        end
        if (e !== cur_exp) begin
            exp_q.push_back('{cyc: n, vec: e});
            cur_exp = e;
        end
    endtask

    task automatic drive(input bit rst, input logic [2:0] keys, input int ncyc);
        repeat (ncyc) begin
            reset       = rst;
            key_clear_n = keys[2];
            key_hold_n  = keys[1];
            key_start_n = keys[0];
            model_edge(rst, keys);
            @(negedge clk);
        end
    endtask

    // Monitor: one comparison per observed or expected output change.
    initial begin : monitor
        logic [2:0] prev;
        logic [2:0] cur;
        ev_t        e;
        prev = 3'b111;
        forever begin
            @(negedge clk);
            cur = {reset_n, hold, start_stop};
            if (cur !== prev) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_change edge=%0d got=%b from=%b (no change due)",
                             cyc, cur, prev);
                end else begin
                    e = exp_q.pop_front();
                    if (e.vec !== cur || e.cyc != cyc) begin
                        failures++;
                        $display("FAIL output_change edge=%0d got=%b required=%b at edge %0d",
                                 cyc, cur, e.vec, e.cyc);
                    end
                end
                prev = cur;
            end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
                e = exp_q.pop_front();
                checks++;
                failures++;
                $display("FAIL missing_change edge=%0d got=%b required=%b at edge %0d",
                         cyc, cur, e.vec, e.cyc);
            end
        end
    end

    initial begin : stimulus
        logic [2:0] mask;
        logic [2:0] r;
        int         dur;
        bit         rs;
        deb_h[0] = 3'b111;
        rst_h[0] = 1'b1;

        drive(1'b1, REL, 3);
        checks++;
        if ({reset_n, hold, start_stop} !== 3'b111) begin
            failures++;
            $display("FAIL reset_state got=%b required=111", {reset_n, hold, start_stop});
        end
        drive(1'b0, REL, 10);

        // Clean start press held for 50 cycles: one pulse.
        drive(1'b0, K_START, 50);
        drive(1'b0, REL, 30);

        // Bouncy hold press, then a clean one.
        drive(1'b0, K_HOLD, 1);
        drive(1'b0, REL, 1);
        drive(1'b0, K_HOLD, 1);
        drive(1'b0, REL, 1);
        drive(1'b0, K_HOLD, 20);
        drive(1'b0, REL, 20);
        drive(1'b0, K_HOLD, 20);
        drive(1'b0, REL, 20);

        // Short clear (no fire), then long clear (one fire).
        drive(1'b0, K_CLEAR, 50);
        drive(1'b0, REL, 20);
        drive(1'b0, K_CLEAR, 150);
        drive(1'b0, REL, 20);

        // Clear fires while hold=0 and a start pulse is running.
        drive(1'b0, K_HOLD, 20);
        drive(1'b0, REL, 20);
        drive(1'b0, K_CLEAR, 95);
        drive(1'b0, K_CLR_STA, 60);
        drive(1'b0, REL, 30);

        // Reset during a start pulse with the key still held.
        drive(1'b0, K_START, 10);
        drive(1'b1, K_START, 2);
        drive(1'b0, K_START, 30);
        drive(1'b0, REL, 30);

        // Two presses landing inside one pulse window.
        drive(1'b0, K_START, 4);
        drive(1'b0, REL, 4);
        drive(1'b0, K_START, 4);
        drive(1'b0, REL, 30);

        // Randomised presses with glitches and occasional resets.
        for (int s = 0; s < 30; s++) begin
            mask = 3'($urandom_range(1, 7));
            case ($urandom_range(0, 2))
                0:       dur = $urandom_range(1, 6);
                1:       dur = $urandom_range(15, 60);
                default: dur = $urandom_range(100, 140);
            endcase
            for (int c = 0; c < dur; c++) begin
                r = ~mask;
                if ($urandom_range(0, 15) == 0) r = r ^ 3'($urandom_range(1, 7));
                rs = ($urandom_range(0, 199) == 0);
                drive(rs, r, 1);
            end
            drive(1'b0, REL, $urandom_range(5, 40));
        end

        drive(1'b0, REL, 250);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL pending_changes got=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
